// File: rtl/thrust_debounce_pkg.sv
// Shared game definitions: thrust-button FSM state encodings and helpers
// that downstream player-control logic can decode.
package thrust_debounce_pkg;

    localparam int unsigned STATE_WIDTH = 2;

    typedef logic [STATE_WIDTH-1:0] btn_state_t;

    localparam btn_state_t ST_IDLE        = 2'd0;
    localparam btn_state_t ST_ARM_PRESS   = 2'd1;
    localparam btn_state_t ST_HELD        = 2'd2;
    localparam btn_state_t ST_ARM_RELEASE = 2'd3;

    // The debounced level is high while the button is accepted as pressed.
    function automatic logic state_is_down(input btn_state_t st);
        return (st == ST_HELD) || (st == ST_ARM_RELEASE);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/thrust_debounce.sv
// Thrust button debouncer: synchronizes, debounces, emits press/release
// pulses and a saturating held-cycle count.
module thrust_debounce
    import thrust_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned HOLD_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_in,
    output logic                  btn_level,
    output logic                  btn_press,
    output logic                  btn_release,
    output logic [HOLD_WIDTH-1:0] hold_cycles
);

    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = {HOLD_WIDTH{1'b1}};

    logic                  s;
    btn_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  press_q, press_d;
    logic                  release_q, release_d;
    logic [HOLD_WIDTH-1:0] hold_q, hold_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
        end
    end

    // Next state: an ARM state needs DEBOUNCE_CYCLES further stable samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_ARM_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_ARM_PRESS: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d = ST_ARM_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_ARM_RELEASE: begin
                if (s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the transition being taken this cycle.
    always_comb begin
        level_d   = state_is_down(state_d);
        press_d   = (state_q == ST_ARM_PRESS) && (state_d == ST_HELD);
        release_d = (state_q == ST_ARM_RELEASE) && (state_d == ST_IDLE);
        hold_d    = hold_q;
        if (press_d) begin
            hold_d = '0;
        end else if (state_is_down(state_q) && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + HOLD_WIDTH'(1);
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign hold_cycles = hold_q;

endmodule
